// File: rtl/ram_sdp_be_clr_if.sv
// Write/read request bus and status for ram_sdp_be_clr.
// The master drives requests; the RAM (slave) returns read data, read-valid and busy.
interface ram_sdp_be_clr_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
);
    logic                      wclk_en;
    logic [ADDR_WIDTH-1:0]     wa;
    logic [DATA_WIDTH/8-1:0]   wen;
    logic [DATA_WIDTH-1:0]     wd;
    logic                      rclk_en;
    logic [ADDR_WIDTH-1:0]     ra;
    logic [DATA_WIDTH-1:0]     rd;
    logic                      rd_valid;
    logic                      busy;

    modport master (
        output wclk_en, wa, wen, wd, rclk_en, ra,
        input  rd, rd_valid, busy
    );

    modport slave (
        input  wclk_en, wa, wen, wd, rclk_en, ra,
        output rd, rd_valid, busy
    );
endinterface

// File: rtl/ram_sdp_be_clr.sv
// Simple dual-port RAM with byte enables and a post-reset zero sweep (RAM_SDP_BE_CLR_FWD_EN: write-to-read forwarding).
// Latency: RD_LATENCY (1 or 2) cycles from read request to rd/rd_valid; sweep takes DEPTH cycles after reset.
// Backpressure: none; one read and one write per cycle, all requests ignored while busy.
module ram_sdp_be_clr #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512,
    parameter int RD_LATENCY = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    ram_sdp_be_clr_if.slave bus
);
    localparam int                    NB      = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
        $error("DATA_WIDTH must be a multiple of 8");
    end
    if (DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("DEPTH exceeds address space");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
        $error("RD_LATENCY must be 1 or 2");
    end

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                  state;
    logic                    busy_q;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic                    ready;
    logic                    wr_in, rd_in, wr_go, rd_go;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [DATA_WIDTH-1:0]   rd_q;
    logic                    vld_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Sweep sequencer: the edge that clears the last word also drops busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
            busy_q <= (INIT_CLEAR != 0);
            cnt    <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state  <= ST_READY;
                        busy_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready = (state == ST_READY);
    assign wr_in = ({1'b0, bus.wa} < DEPTH_W);
    assign rd_in = ({1'b0, bus.ra} < DEPTH_W);
    assign wr_go = ready && bus.wclk_en && wr_in;
    assign rd_go = ready && bus.rclk_en;

    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[cnt] <= '0;
        end else if (wr_go) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wen[i]) mem[bus.wa][8*i +: 8] <= bus.wd[8*i +: 8];
            end
        end
    end

    // Read-first: the array is sampled before this edge's write lands.
    always_comb begin
        rdata = '0;
        if (rd_in) rdata = mem[bus.ra];
`ifdef RAM_SDP_BE_CLR_FWD_EN
        if (rd_in && wr_go && (bus.wa == bus.ra)) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wen[i]) rdata[8*i +: 8] = bus.wd[8*i +: 8];
            end
        end
`endif
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s1_dat;
        logic                  s1_vld;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_dat <= '0;
                s1_vld <= 1'b0;
                rd_q   <= '0;
                vld_q  <= 1'b0;
            end else begin
                s1_vld <= rd_go;
                if (rd_go) s1_dat <= rdata;
                vld_q <= s1_vld;
                if (s1_vld) rd_q <= s1_dat;
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q  <= '0;
                vld_q <= 1'b0;
            end else begin
                vld_q <= rd_go;
                if (rd_go) rd_q <= rdata;
            end
        end
    end

    assign bus.rd       = rd_q;
    assign bus.rd_valid = vld_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_ram_sdp_be_clr.sv
// Bench for ram_sdp_be_clr: three instances (latency 1, latency 2, DEPTH=300) driven in lockstep,
// read results checked against a per-instance scoreboard of expected data and arrival cycle.
module tb_ram_sdp_be_clr;
`ifdef RAM_SDP_BE_CLR_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [8:0]  wa;
        logic [3:0]  wen;
        logic [31:0] wd;
        logic        re;
        logic [8:0]  ra;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        int          due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    exp_t        sbq [3][$];
    vec_t        tbl [27];
    logic        vld_a  [3];
    logic        busy_a [3];
    logic [31:0] rd_a   [3];

    ram_sdp_be_clr_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) if0 ();
    ram_sdp_be_clr_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) if1 ();
    ram_sdp_be_clr_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) if2 ();

    ram_sdp_be_clr #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(512), .RD_LATENCY(1), .INIT_CLEAR(1))
        u_l1 (.clk(clk), .rst_n(rst_n), .bus(if0));
    ram_sdp_be_clr #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(512), .RD_LATENCY(2), .INIT_CLEAR(1))
        u_l2 (.clk(clk), .rst_n(rst_n), .bus(if1));
    ram_sdp_be_clr #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(300), .RD_LATENCY(1), .INIT_CLEAR(1))
        u_d300 (.clk(clk), .rst_n(rst_n), .bus(if2));

    assign vld_a[0]  = if0.rd_valid;
    assign vld_a[1]  = if1.rd_valid;
    assign vld_a[2]  = if2.rd_valid;
    assign busy_a[0] = if0.busy;
    assign busy_a[1] = if1.busy;
    assign busy_a[2] = if2.busy;
    assign rd_a[0]   = if0.rd;
    assign rd_a[1]   = if1.rd;
    assign rd_a[2]   = if2.rd;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(int k);
        return (k == 1) ? 2 : 1;
    endfunction

    function automatic int depth_of(int k);
        return (k == 2) ? 300 : 512;
    endfunction

    function automatic vec_t mk(logic we, logic [8:0] wa, logic [3:0] wen, logic [31:0] wd,
                                logic re, logic [8:0] ra, logic [31:0] exp);
        vec_t v;
        v.we = we; v.wa = wa; v.wen = wen; v.wd = wd;
        v.re = re; v.ra = ra; v.exp = exp;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every valid must match the oldest expectation, on its due cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (vld_a[k] === 1'b1) begin
                if (sbq[k].size() == 0) begin
                    check($sformatf("dut%0d_unexpected_valid", k), 32'(vld_a[k]), 32'd0);
                end else begin
                    exp_t e;
                    e = sbq[k].pop_front();
                    check($sformatf("dut%0d_rd_data", k), rd_a[k], e.dat);
                    check($sformatf("dut%0d_rd_cycle", k), 32'(cyc), 32'(e.due));
                end
            end else if (sbq[k].size() > 0 && sbq[k][0].due <= cyc) begin
                exp_t e;
                e = sbq[k].pop_front();
                check($sformatf("dut%0d_missing_valid", k), 32'(vld_a[k]), 32'd1);
            end
        end
    end

    task automatic push_all(logic [8:0] ra, logic [31:0] exp);
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.dat = (int'(ra) >= depth_of(k)) ? 32'd0 : exp;
            e.due = cyc + lat_of(k);
            sbq[k].push_back(e);
        end
    endtask

    task automatic drive(vec_t v);
        if0.wclk_en = v.we; if0.wa = v.wa; if0.wen = v.wen; if0.wd = v.wd; if0.rclk_en = v.re; if0.ra = v.ra;
        if1.wclk_en = v.we; if1.wa = v.wa; if1.wen = v.wen; if1.wd = v.wd; if1.rclk_en = v.re; if1.ra = v.ra;
        if2.wclk_en = v.we; if2.wa = v.wa; if2.wen = v.wen; if2.wd = v.wd; if2.rclk_en = v.re; if2.ra = v.ra;
        if (v.re) push_all(v.ra, v.exp);
    endtask

    task automatic idle();
        drive(mk(1'b0, 9'h0, 4'h0, 32'h0, 1'b0, 9'h0, 32'h0));
    endtask

    // Counts negedges with busy high after release; requests stay asserted until each busy falls.
    task automatic busy_sweep(string tag);
        int cnt [3];
        for (int k = 0; k < 3; k++) cnt[k] = 0;
        for (int t = 0; t < 2000 && (if0.busy || if1.busy || if2.busy); t++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (busy_a[k]) cnt[k]++;
            if (!if0.busy) begin if0.wclk_en = 1'b0; if0.rclk_en = 1'b0; end
            if (!if1.busy) begin if1.wclk_en = 1'b0; if1.rclk_en = 1'b0; end
            if (!if2.busy) begin if2.wclk_en = 1'b0; if2.rclk_en = 1'b0; end
        end
        for (int k = 0; k < 3; k++)
            check($sformatf("dut%0d_%s_busy_cycles", k, tag), 32'(cnt[k]), 32'(depth_of(k)));
        idle();
    endtask

    initial begin
        tbl[0]  = mk(1, 9'h005, 4'hF, 32'hAABBCCDD, 0, 9'h000, 32'h0);
        tbl[1]  = mk(1, 9'h005, 4'h2, 32'h11223344, 0, 9'h000, 32'h0);
        tbl[2]  = mk(0, 9'h000, 4'h0, 32'h0,        1, 9'h005, 32'hAABB33DD);
        tbl[3]  = mk(0, 9'h000, 4'h0, 32'h0,        1, 9'h000, 32'h0);
        tbl[4]  = mk(0, 9'h000, 4'h0, 32'h0,        1, 9'h1FF, 32'h0);
        tbl[5]  = mk(0, 9'h000, 4'h0, 32'h0,        1, 9'h006, 32'h0);
        tbl[6]  = mk(1, 9'h010, 4'hF, 32'hAABBCCDD, 0, 9'h000, 32'h0);
        tbl[7]  = mk(1, 9'h010, 4'hF, 32'h12345678, 1, 9'h010, FWD ? 32'h12345678 : 32'hAABBCCDD);
        tbl[8]  = mk(0, 9'h000, 4'h0, 32'h0,        1, 9'h010, 32'h12345678);
        tbl[9]  = mk(1, 9'h010, 4'hF, 32'hAABBCCDD, 0, 9'h000, 32'h0);
        tbl[10] = mk(1, 9'h010, 4'h1, 32'h12345678, 1, 9'h010, FWD ? 32'hAABBCC78 : 32'hAABBCCDD);
        tbl[11] = mk(0, 9'h000, 4'h0, 32'h0,        1, 9'h010, 32'hAABBCC78);
        tbl[12] = mk(1, 9'h1F0, 4'hF, 32'hDEADBEEF, 0, 9'h000, 32'h0);
        tbl[13] = mk(0, 9'h000, 4'h0, 32'h0,        1, 9'h1F0, 32'hDEADBEEF);
        tbl[14] = mk(0, 9'h000, 4'h0, 32'h0,        1, 9'h12B, 32'h0);
        tbl[15] = mk(1, 9'h12B, 4'hF, 32'h0BADF00D, 1, 9'h1F0, 32'hDEADBEEF);
        tbl[16] = mk(0, 9'h000, 4'h0, 32'h0,        1, 9'h12B, 32'h0BADF00D);
        tbl[17] = mk(1, 9'h12B, 4'h0, 32'hFFFFFFFF, 0, 9'h000, 32'h0);
        tbl[18] = mk(0, 9'h000, 4'h0, 32'h0,        1, 9'h12B, 32'h0BADF00D);
        tbl[19] = mk(1, 9'h020, 4'h8, 32'h55AA55AA, 1, 9'h005, 32'hAABB33DD);
        tbl[20] = mk(0, 9'h000, 4'h0, 32'h0,        1, 9'h020, 32'h55000000);
        tbl[21] = mk(1, 9'h001, 4'hF, 32'h01010101, 0, 9'h000, 32'h0);
        tbl[22] = mk(1, 9'h002, 4'hF, 32'h02020202, 0, 9'h000, 32'h0);
        tbl[23] = mk(1, 9'h003, 4'hF, 32'h03030303, 0, 9'h000, 32'h0);
        tbl[24] = mk(0, 9'h000, 4'h0, 32'h0,        1, 9'h001, 32'h01010101);
        tbl[25] = mk(0, 9'h000, 4'h0, 32'h0,        1, 9'h002, 32'h02020202);
        tbl[26] = mk(0, 9'h000, 4'h0, 32'h0,        1, 9'h003, 32'h03030303);

        rst_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("dut%0d_reset_busy", k), 32'(busy_a[k]), 32'd1);
            check($sformatf("dut%0d_reset_rd", k), rd_a[k], 32'd0);
            check($sformatf("dut%0d_reset_valid", k), 32'(vld_a[k]), 32'd0);
        end

        // Requests during the sweep must be ignored (no valids, no write to 0x006).
        if0.wclk_en = 1; if0.wa = 9'h006; if0.wen = 4'hF; if0.wd = 32'hFFFFFFFF; if0.rclk_en = 1; if0.ra = 9'h006;
        if1.wclk_en = 1; if1.wa = 9'h006; if1.wen = 4'hF; if1.wd = 32'hFFFFFFFF; if1.rclk_en = 1; if1.ra = 9'h006;
        if2.wclk_en = 1; if2.wa = 9'h006; if2.wen = 4'hF; if2.wd = 32'hFFFFFFFF; if2.rclk_en = 1; if2.ra = 9'h006;
        rst_n = 1'b1;
        busy_sweep("initial");

        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            drive(tbl[i]);
        end
        @(negedge clk);
        idle();

        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("dut%0d_hold_rd", k), rd_a[k], 32'h03030303);
            check($sformatf("dut%0d_hold_valid", k), 32'(vld_a[k]), 32'd0);
            check($sformatf("dut%0d_queue_drained", k), 32'(sbq[k].size()), 32'd0);
        end

        // Reset with a read in flight: outputs drop at once.
        @(negedge clk);
        if0.rclk_en = 1; if0.ra = 9'h001;
        if1.rclk_en = 1; if1.ra = 9'h001;
        if2.rclk_en = 1; if2.ra = 9'h001;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) sbq[k].delete();
        idle();
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("dut%0d_midop_rd", k), rd_a[k], 32'd0);
            check($sformatf("dut%0d_midop_valid", k), 32'(vld_a[k]), 32'd0);
            check($sformatf("dut%0d_midop_busy", k), 32'(busy_a[k]), 32'd1);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Interrupt the sweep at count 100; it must restart from zero.
        repeat (100) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("dut%0d_resweep_busy", k), 32'(busy_a[k]), 32'd1);
        rst_n = 1'b1;
        busy_sweep("restart");

        @(negedge clk);
        drive(mk(0, 9'h000, 4'h0, 32'h0, 1, 9'h005, 32'h0));
        @(negedge clk);
        drive(mk(0, 9'h000, 4'h0, 32'h0, 1, 9'h1FF, 32'h0));
        @(negedge clk);
        idle();
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++)
            check($sformatf("dut%0d_final_drained", k), 32'(sbq[k].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_sdp_be_clr.md
Name: ram_sdp_be_clr

Overview:
- Parametrised single-clock simple dual-port RAM with per-byte write enables.
- Configurable read latency of 1 or 2 and a read-valid flag.
- Hardware clear sequencer zeroes the array after reset, flagged by Busy.
- Replaces fixed 512x32 inferred-RAM instances in datapath buffers; maps to block RAM with the output register absorbed when RD_LATENCY=2.

Parameters:
ADDR_WIDTH, 9, address bits.
DATA_WIDTH, 32, word width; must be a multiple of 8.
DEPTH, 512, number of words; must be <= 2**ADDR_WIDTH.
RD_LATENCY, 1, read pipeline depth; legal values 1 or 2.
INIT_CLEAR, 1, 1 = sweep the array to zero after reset; 0 = no sweep.

Ports:
Clk  in  1  single clock, rising edge.
Rst_n  in  1  asynchronous active-low reset.
WClk_En  in  1  write qualifier.
WA  in  ADDR_WIDTH  write address.
WEN  in  DATA_WIDTH/8  byte write enables; bit i covers WD[8i+7:8i].
WD  in  DATA_WIDTH  write data.
RClk_En  in  1  read request.
RA  in  ADDR_WIDTH  read address.
RD  out  DATA_WIDTH  read data.
RD_Valid  out  1  RD carries data for a request made RD_LATENCY cycles earlier.
Busy  out  1  clear sweep in progress; all requests ignored.

Behaviour:
- Reset (Rst_n low, asynchronous):
  - RD=0, RD_Valid=0, internal pipeline and valid shift register cleared.
  - Clear counter=0; state=CLEAR if INIT_CLEAR=1, else READY.
  - Busy=1 in CLEAR, 0 in READY.
  - Array contents are not reset asynchronously.
- State CLEAR:
  - Each Clk edge writes 0 to mem[cnt] and increments cnt.
  - The edge that writes cnt==DEPTH-1 moves to READY; Busy low from that edge.
  - Sweep takes exactly DEPTH cycles after reset release.
  - WClk_En and RClk_En ignored; RD_Valid stays 0.
- State READY: terminal until the next reset.
- Write (READY, WClk_En=1):
  - For every i with WEN[i]=1: mem[WA][8i+7:8i] <= WD[8i+7:8i].
  - Bytes with WEN[i]=0 are unchanged; WEN=0 is a no-op.
- Read (READY, RClk_En=1):
  - RD_LATENCY=1: RD=mem[RA] and RD_Valid=1 after one edge.
  - RD_LATENCY=2: array read register, then output register. RD and RD_Valid appear two edges after the request.
  - The pipeline never stalls; back-to-back requests give back-to-back valids.
- No request (RClk_En=0): final RD holds its last value; RD_Valid=0 for the corresponding output cycle.
- Read/write collision (same edge, WA==RA, both enabled): read-first. RD returns pre-write contents unless RAM_FWD_EN is defined. The next read returns the new data.
- Out-of-range addresses (WA or RA >= DEPTH):
  - Write dropped.
  - Read returns 0 with RD_Valid=1.
- Reset asserted mid-operation:
  - In-flight reads are discarded; RD_Valid=0 immediately.
  - A sweep in progress restarts from address 0.
  - A write on the same edge as reset assertion is not guaranteed.
- Simultaneous read and write to different addresses are independent, one each per cycle.

Optional Feature:
- Macro: RAM_SDP_BE_CLR_FWD_EN (referred to above as RAM_FWD_EN).
- Defined: on a collision, RD returns merged data: bytes with WEN[i]=1 take WD, the rest take old contents. Same latency as a normal read.
- Undefined: read-first behaviour as stated above; no forwarding mux or compare logic is synthesised.

Test Plan:
1. Default params, INIT_CLEAR=1, release reset -> Busy=1 for exactly 512 cycles. After Busy falls, reads of 0x000 and 0x1FF return 0x00000000 with RD_Valid=1 one cycle later.
2. Write 0xAABBCCDD to 0x005 with WEN=4'hF, then 0x11223344 with WEN=4'b0010, read 0x005 -> RD=0xAABB33DD.
3. Collision: mem[0x010]=0xAABBCCDD; same edge write 0x12345678 (WEN=4'hF) and read 0x010 -> RD=0xAABBCCDD without macro, 0x12345678 with macro. Following read -> 0x12345678. With macro and WEN=4'b0001 -> 0xAABBCC78.
4. RD_LATENCY=2, reads of 0x001, 0x002, 0x003 on consecutive cycles -> RD_Valid high for 3 consecutive cycles starting 2 edges after the first request, data in order. RClk_En low afterwards -> RD holds 0x003's data, RD_Valid=0.
5. Assert Rst_n low at sweep count 100 for 2 cycles -> RD=0 and RD_Valid=0 immediately, Busy stays 1. Sweep restarts; Busy falls 512 cycles after release.
6. DEPTH=300, ADDR_WIDTH=9: write 0xDEADBEEF to 0x1F0, read 0x1F0 -> RD=0 with RD_Valid=1. Read 0x12B -> last written value (0 after clear).
